// File: rtl/mulinv_mod.sv
// Multiplicative inverse modulo 65537 (0 encodes 65536), computed as x^65535 by
// square-and-multiply on a single shared modular multiplier.
module mulinv_mod #(
  parameter bit SHORTCUT = 1'b0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] operand,
  output logic        busy,
  output logic        done,
  output logic [15:0] result
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSqr  = 2'd1;
  localparam logic [1:0] StMul  = 2'd2;
  localparam logic [1:0] StFin  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] base_q, base_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] result_q, result_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Shared multiplier: squares in StSqr, multiplies by the base in StMul.
  logic [15:0] mul_b;
  logic [16:0] ea, eb;
  logic [32:0] prod;
  logic [17:0] diff;
  logic [15:0] mm_res;

  assign mul_b = (state_q == StSqr) ? acc_q : base_q;
  assign ea    = (acc_q == 16'd0) ? 17'h10000 : {1'b0, acc_q};
  assign eb    = (mul_b == 16'd0) ? 17'h10000 : {1'b0, mul_b};
  assign prod  = {16'd0, ea} * {16'd0, eb};

  // 2^16 == -1 (mod 65537), so p mod 65537 == lo - hi, folded back into range.
  assign diff   = {2'b00, prod[15:0]} - {1'b0, prod[32:16]};
  assign mm_res = 16'(diff[17] ? diff + 18'd65537 : diff);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // done_q high means this is the done cycle, where start is not taken.
        if (start && !done_q) begin
          base_d = operand;
          acc_d  = operand;
          cnt_d  = 4'd15;
          if (SHORTCUT && (operand <= 16'd1)) state_d = StFin;
          else                                state_d = StSqr;
        end
      end
      StSqr: begin
        acc_d   = mm_res;
        state_d = StMul;
      end
      StMul: begin
        acc_d   = mm_res;
        cnt_d   = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? StFin : StSqr;
      end
      StFin: begin
        result_d = acc_q;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StSqr) || (state_d == StMul);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      base_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mulinv_mod.sv
// Scoreboard bench for mulinv_mod: one instance without and one with the 0/1 shortcut.
module tb_mulinv_mod;

  typedef struct packed {
    logic [15:0] op;
    logic [15:0] res;
    int          due;
    int          bc;
  } exp_t;

  logic        clock;
  logic        reset_n;
  logic        start_s [2];
  logic [15:0] op_s    [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic [15:0] res_s   [2];

  exp_t q0[$];
  exp_t q1[$];
  int   cyc;
  int   bcnt [2];
  logic done_prev [2];
  int   n_checks;
  int   n_pass;

  mulinv_mod #(.SHORTCUT(1'b0)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .start(start_s[0]), .operand(op_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .result(res_s[0])
  );

  mulinv_mod #(.SHORTCUT(1'b1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .start(start_s[1]), .operand(op_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .result(res_s[1])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  function automatic logic [15:0] mm_ref(logic [15:0] a, logic [15:0] b);
    longint ea, eb, p;
    ea = (a == 16'd0) ? 65536 : longint'(a);
    eb = (b == 16'd0) ? 65536 : longint'(b);
    p  = (ea * eb) % 65537;
    return 16'(p);
  endfunction

  // Extended Euclid, independent of the exponentiation the design uses.
  function automatic logic [15:0] inv_ref(logic [15:0] op);
    longint t, nt, r, nr, qq, tmp;
    t  = 0;
    nt = 1;
    r  = 65537;
    nr = (op == 16'd0) ? 65536 : longint'(op);
    while (nr != 0) begin
      qq  = r / nr;
      tmp = t - qq * nt; t = nt; nt = tmp;
      tmp = r - qq * nr; r = nr; nr = tmp;
    end
    if (t < 0) t += 65537;
    return (t == 65536) ? 16'd0 : 16'(t);
  endfunction

  task automatic push(int i, logic [15:0] op, logic [15:0] res, int due, int bc);
    exp_t e;
    e.op  = op;
    e.res = res;
    e.due = due;
    e.bc  = bc;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic mon_one(int i);
    exp_t e;
    int   sz;
    sz = (i == 0) ? q0.size() : q1.size();
    if (!reset_n) bcnt[i] = 0;
    else if (busy_s[i]) bcnt[i]++;
    if (done_s[i]) begin
      check_val("done_single", 32'(done_prev[i]), 0);
      if (sz == 0) begin
        check_val("unexpected_done", 32'(done_s[i]), 0);
      end else begin
        if (i == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check_val("result", 32'(res_s[i]), 32'(e.res));
        check_val("latency", cyc, e.due);
        check_val("busy_cycles", bcnt[i], e.bc);
        check_val("mm_identity", 32'(mm_ref(e.op, res_s[i])), 1);
      end
      bcnt[i] = 0;
    end
    done_prev[i] = done_s[i];
  endtask

  initial begin
    bcnt[0] = 0; bcnt[1] = 0;
    done_prev[0] = 1'b0; done_prev[1] = 1'b0;
    forever begin
      @(negedge clock);
      mon_one(0);
      mon_one(1);
    end
  end

  // Accept edge N is the edge at which start is sampled; done shows up at edge N+lat.
  task automatic issue(int i, logic [15:0] op, logic [15:0] res, int lat, int bc);
    @(negedge clock);
    start_s[i] = 1'b1;
    op_s[i]    = op;
    @(posedge clock);
    #1;
    push(i, op, res, cyc + lat, bc);
    start_s[i] = 1'b0;
    op_s[i]    = 16'($urandom);
  endtask

  task automatic wait_idle(int i);
    int sz;
    sz = (i == 0) ? q0.size() : q1.size();
    for (int k = 0; k < 60 && sz != 0; k++) begin
      @(negedge clock);
      sz = (i == 0) ? q0.size() : q1.size();
    end
    check_val("drain_timeout", sz, 0);
  endtask

  task automatic run(int i, logic [15:0] op, logic [15:0] res);
    int lat;
    int bc;
    lat = (i == 1 && op <= 16'd1) ? 1 : 31;
    bc  = (lat == 1) ? 0 : 30;
    issue(i, op, res, lat, bc);
    wait_idle(i);
  endtask

  initial begin
    logic [15:0] r_op;
    n_checks = 0;
    n_pass   = 0;
    reset_n    = 1'b0;
    start_s[0] = 1'b1; op_s[0] = 16'd5;
    start_s[1] = 1'b1; op_s[1] = 16'd5;

    // Reset dominates a held start.
    @(posedge clock);
    repeat (4) begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        check_val("rst_busy", 32'(busy_s[i]), 0);
        check_val("rst_done", 32'(done_s[i]), 0);
        check_val("rst_result", 32'(res_s[i]), 0);
      end
    end
    start_s[0] = 1'b0; start_s[1] = 1'b0;
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check_val("no_done_after_reset", 32'(done_s[0]), 0);
      check_val("no_busy_after_reset", 32'(busy_s[0]), 0);
    end

    run(0, 16'd2, 16'd32769);
    run(0, 16'd3, 16'd21846);
    run(0, 16'd0, 16'd0);
    run(0, 16'd1, 16'd1);
    run(0, 16'd65535, 16'd32768);
    run(0, 16'd32768, 16'd65535);

    run(1, 16'd0, 16'd0);
    run(1, 16'd1, 16'd1);
    run(1, 16'd7, 16'd18725);

    // start pulse with another operand while busy is ignored.
    issue(0, 16'd2, 16'd32769, 31, 30);
    repeat (5) @(negedge clock);
    start_s[0] = 1'b1; op_s[0] = 16'd9;
    @(negedge clock);
    start_s[0] = 1'b0;
    wait_idle(0);

    // start held from the done cycle: ignored there, taken on the following edge.
    issue(0, 16'd3, 16'd21846, 31, 30);
    for (int k = 0; k < 40 && !done_s[0]; k++) @(negedge clock);
    check_val("done_seen", 32'(done_s[0]), 1);
    start_s[0] = 1'b1; op_s[0] = 16'd9;
    @(posedge clock);
    #1;
    check_val("start_in_done_ignored", 32'(busy_s[0]), 0);
    @(posedge clock);
    #1;
    push(0, 16'd9, inv_ref(16'd9), cyc + 31, 30);
    start_s[0] = 1'b0;
    check_val("start_after_done_taken", 32'(busy_s[0]), 1);
    wait_idle(0);

    // Reset in the middle of a computation drops it without a done.
    issue(0, 16'd1234, inv_ref(16'd1234), 31, 30);
    repeat (11) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    q0.delete();
    check_val("midrst_busy", 32'(busy_s[0]), 0);
    check_val("midrst_done", 32'(done_s[0]), 0);
    check_val("midrst_result", 32'(res_s[0]), 0);
    reset_n = 1'b1;
    repeat (40) begin
      @(negedge clock);
      check_val("midrst_no_done", 32'(done_s[0]), 0);
    end

    for (int n = 0; n < 1000; n++) begin
      r_op = 16'($urandom_range(0, 65535));
      run(0, r_op, inv_ref(r_op));
    end

    wait_idle(0);
    wait_idle(1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mulinv_mod.md
Name: mulinv_mod

Overview:
- Sequential multiplicative-inverse unit over the diminished-one modulo-65537 domain used by the datapath's modular multiply (16-bit operand 0 encodes 65536).
- Computes the inverse as x^65535 mod 65537 (Fermat) using square-and-multiply on one shared 17x17 modular multiplier.
- It is the decrypt-side companion: it turns forward multiply keys into inverse keys.
- Sits beside the ALU and is driven by the key-schedule sequencer through a start/done handshake.

Parameters:
SHORTCUT, 0, when 1 operands 0 and 1 (both self-inverse) complete with 1-cycle latency; when 0 all operands take the full fixed latency

Ports:
clock  input  1  system clock, all state updates on rising edge
reset_n  input  1  synchronous active-low reset
start  input  1  request; accepted only on a rising edge where busy=0
operand  input  16  value to invert, sampled on the accepting edge; 0 means 65536
busy  output  1  high while an inversion is in progress
done  output  1  one-cycle pulse: result is valid
result  output  16  inverse, same encoding as operand; 65536 encoded as 0

Behaviour:
- Reset (reset_n=0 at an edge): state IDLE, busy=0, done=0, result=0, internal accumulator/base/counter cleared. This applies also mid-operation: the in-flight inversion is discarded and no done is produced.
- Modular multiply rule, mm(a,b):
  - a'=(a==0)?65536:a; b' likewise.
  - p=(a'*b') mod 65537; return p[15:0], so 65536 maps to 0.
  - Must be exact for all 2^32 operand pairs, including 0*0 → 1 (65536^2 ≡ 1).
- States: IDLE, SQR, MUL, FIN.
- IDLE:
  - On start=1, latch base=operand, acc=operand, cnt=15, go to SQR; busy=1 from the next cycle.
  - If SHORTCUT=1 and operand is 0 or 1, go directly to FIN with acc=operand; busy stays 0.
- SQR: acc<=mm(acc,acc), go to MUL.
- MUL: acc<=mm(acc,base), cnt<=cnt-1; if cnt==1 go to FIN, else go to SQR.
- FIN: result<=acc registered so that done=1 and result valid in the same cycle; busy=0. The next edge returns to IDLE.
- Timing: start accepted at edge N; compute edges N+1..N+30 (15 SQR/MUL pairs); done high during the cycle after edge N+31. Total latency 31 cycles from accept to done. Shortcut latency: done during the cycle after edge N+1.
- busy is high exactly for the 30 compute cycles.
- start is ignored while busy=1, and also while in FIN (done cycle); a new start is accepted from IDLE onward, i.e. the edge after the done cycle at the earliest. operand changes while busy have no effect.
- result holds its last value until the next FIN; it is not cleared on start.
- done never asserts for two consecutive cycles.
- Registered outputs only; no combinational path from start/operand to any output.

Test Plan:
1. Reset with start=1, operand=5 held through reset → busy=0, done=0, result=0 throughout; no done after release until a new start.
2. operand=2 start → busy high 30 cycles, done pulse at cycle 31 with result=32769. Then operand=3 → result=21846.
3. operand=0 → result=0; operand=1 → result=1; operand=65535 → result=32768; operand=32768 → result=65535. All with SHORTCUT=0, 31-cycle latency each.
4. SHORTCUT=1: operand=0 → done after 1 cycle, result=0, busy never high. operand=7 → full latency, and result*7 mod 65537 =1 (result=18725).
5. During busy, pulse start with operand=9 → ignored, original result delivered. Start asserted in the done cycle → ignored. Start asserted the cycle after done → accepted.
6. reset_n low at compute cycle 12 → busy/done/result cleared next edge, no done pulse. Then a random sweep of 1000 operands against a reference model confirms mm(operand,result)=1 for each.
